// File: rtl/usb_line_detect.sv
// ---------------------------------------------------------------------------
// usb_line_detect
//
// Conditions the raw D+/D- pad inputs in front of a USB1.1 host and tracks
// device attach/detach.
//   * Each pad line goes through a SYNC_STAGES-deep synchroniser. The last
//     stage feeds the host receiver directly, with no filtering.
//   * line_state_o is a glitch-filtered copy of the synchronised pair. It only
//     moves after FILT_LEN consecutive identical samples.
//   * A debounced attach/detach FSM reports presence and speed, pulses
//     attach/detach events and keeps a sticky connect-change interrupt.
//
// Ports
//   usb_clk_i       in   USB clock (single clock domain)
//   usb_rst_i       in   asynchronous active-high reset
//   pad_dp_i        in   raw D+ from the pad (asynchronous)
//   pad_dn_i        in   raw D- from the pad (asynchronous)
//   host_drv_i      in   1 while the host transmitter drives the bus
//   intr_clr_i      in   single-cycle clear for intr_o
//   in_dp_o         out  synchronised D+ to the host receiver
//   in_dn_o         out  synchronised D- to the host receiver
//   line_state_o    out  filtered {dp,dn}: 00 SE0, 10 FS-J, 01 LS-J, 11 SE1
//   dev_attached_o  out  device present
//   dev_speed_o     out  1 = full speed, 0 = low speed (valid while attached)
//   attach_evt_o    out  one-cycle pulse on attach
//   detach_evt_o    out  one-cycle pulse on detach
//   intr_o          out  sticky connect-change interrupt
// ---------------------------------------------------------------------------
module usb_line_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int DEB_CYCLES  = 4800000,
  parameter int DISC_CYCLES = 120
) (
  input  logic       usb_clk_i,
  input  logic       usb_rst_i,
  input  logic       pad_dp_i,
  input  logic       pad_dn_i,
  input  logic       host_drv_i,
  input  logic       intr_clr_i,
  output logic       in_dp_o,
  output logic       in_dn_o,
  output logic [1:0] line_state_o,
  output logic       dev_attached_o,
  output logic       dev_speed_o,
  output logic       attach_evt_o,
  output logic       detach_evt_o,
  output logic       intr_o
);

  localparam int CNT_MAX = (DEB_CYCLES > DISC_CYCLES) ? DEB_CYCLES : DISC_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DISC_LAST = CNT_W'(DISC_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_DETACHED    = 2'b00,
    ST_ATTACH_WAIT = 2'b01,
    ST_ATTACHED    = 2'b10,
    ST_DETACH_WAIT = 2'b11
  } state_e;

  // ------------------------------------------------------------------
  // Synchroniser: bit 0 samples the pad, the MSB is the output stage.
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_dp_q, sync_dp_d;
  logic [SYNC_STAGES-1:0] sync_dn_q, sync_dn_d;
  logic [1:0]             sync_pair_s;

  // Shift each pad line one stage deeper per clock
  always_comb begin
    sync_dp_d = {sync_dp_q[SYNC_STAGES-2:0], pad_dp_i};
    sync_dn_d = {sync_dn_q[SYNC_STAGES-2:0], pad_dn_i};
  end

  // Synchroniser flops
  always_ff @(posedge usb_clk_i or posedge usb_rst_i) begin
    if (usb_rst_i) begin
      sync_dp_q <= {SYNC_STAGES{1'b0}};
      sync_dn_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_dp_q <= sync_dp_d;
      sync_dn_q <= sync_dn_d;
    end
  end

  assign sync_pair_s = {sync_dp_q[SYNC_STAGES-1], sync_dn_q[SYNC_STAGES-1]};
  assign in_dp_o     = sync_dp_q[SYNC_STAGES-1];
  assign in_dn_o     = sync_dn_q[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // Glitch filter. The history window is the current synchronised pair
  // plus FILT_LEN-1 older pairs. The window is stable when every entry
  // matches.
  // ------------------------------------------------------------------
  logic       filt_stable_s;
  logic [1:0] line_state_q, line_state_d;

  generate
    if (FILT_LEN > 1) begin : g_hist
      logic [1:0] hist_q [FILT_LEN-1];
      logic [1:0] hist_d [FILT_LEN-1];

      // Push the current synchronised pair into the history
      always_comb begin
        hist_d[0] = sync_pair_s;
        for (int i = 1; i < FILT_LEN - 1; i++) begin
          hist_d[i] = hist_q[i-1];
        end
      end

      // History flops
      always_ff @(posedge usb_clk_i or posedge usb_rst_i) begin
        if (usb_rst_i) begin
          for (int i = 0; i < FILT_LEN - 1; i++) begin
            hist_q[i] <= 2'b00;
          end
        end else begin
          for (int i = 0; i < FILT_LEN - 1; i++) begin
            hist_q[i] <= hist_d[i];
          end
        end
      end

      // Window is stable when every stored pair equals the current pair
      always_comb begin
        filt_stable_s = 1'b1;
        for (int i = 0; i < FILT_LEN - 1; i++) begin
          filt_stable_s = filt_stable_s & (hist_q[i] == sync_pair_s);
        end
      end
    end else begin : g_nohist
      assign filt_stable_s = 1'b1;
    end
  endgenerate

  // Filtered line state follows the pair once the window is stable
  always_comb begin
    if (filt_stable_s) begin
      line_state_d = sync_pair_s;
    end else begin
      line_state_d = line_state_q;
    end
  end

  // Filtered line state flop
  always_ff @(posedge usb_clk_i or posedge usb_rst_i) begin
    if (usb_rst_i) begin
      line_state_q <= 2'b00;
    end else begin
      line_state_q <= line_state_d;
    end
  end

  assign line_state_o = line_state_q;

  // ------------------------------------------------------------------
  // Attach/detach FSM with one shared debounce counter.
  // ------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             spd_lat_q, spd_lat_d;
  logic [1:0]       j_pair_s;
  logic             attach_hit_s;
  logic             detach_hit_s;

  // The J pair latched on entry to ATTACH_WAIT, rebuilt from the speed bit
  assign j_pair_s = spd_lat_q ? 2'b10 : 2'b01;

  // FSM state, counter and latched-speed flops
  always_ff @(posedge usb_clk_i or posedge usb_rst_i) begin
    if (usb_rst_i) begin
      state_q   <= ST_DETACHED;
      cnt_q     <= {CNT_W{1'b0}};
      spd_lat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      spd_lat_q <= spd_lat_d;
    end
  end

  // Next-state logic; the counter clears on every state change
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    spd_lat_d    = spd_lat_q;
    attach_hit_s = 1'b0;
    detach_hit_s = 1'b0;
    case (state_q)
      ST_DETACHED: begin
        if ((line_state_q == 2'b10) || (line_state_q == 2'b01)) begin
          state_d   = ST_ATTACH_WAIT;
          cnt_d     = {CNT_W{1'b0}};
          spd_lat_d = line_state_q[1];
        end else begin
          state_d = ST_DETACHED;
        end
      end
      ST_ATTACH_WAIT: begin
        if (line_state_q != j_pair_s) begin
          state_d = ST_DETACHED;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == DEB_LAST) begin
          state_d      = ST_ATTACHED;
          cnt_d        = {CNT_W{1'b0}};
          attach_hit_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ATTACHED: begin
        if ((line_state_q == 2'b00) && !host_drv_i) begin
          state_d = ST_DETACH_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_ATTACHED;
        end
      end
      ST_DETACH_WAIT: begin
        // A host-driven SE0 (bus reset, EOP) must never look like a detach
        if (host_drv_i || (line_state_q != 2'b00)) begin
          state_d = ST_ATTACHED;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == DISC_LAST) begin
          state_d      = ST_DETACHED;
          cnt_d        = {CNT_W{1'b0}};
          detach_hit_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_DETACHED;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Registered outputs. Events coincide with the dev_attached_o edge.
  // ------------------------------------------------------------------
  logic dev_attached_q, dev_attached_d;
  logic dev_speed_q, dev_speed_d;
  logic attach_evt_q, attach_evt_d;
  logic detach_evt_q, detach_evt_d;
  logic intr_q, intr_d;

  // Output decode from the FSM transitions; interrupt set beats clear
  always_comb begin
    attach_evt_d = attach_hit_s;
    detach_evt_d = detach_hit_s;
    if (attach_hit_s) begin
      dev_attached_d = 1'b1;
      dev_speed_d    = spd_lat_q;
    end else if (detach_hit_s) begin
      dev_attached_d = 1'b0;
      dev_speed_d    = dev_speed_q;
    end else begin
      dev_attached_d = dev_attached_q;
      dev_speed_d    = dev_speed_q;
    end
    if (attach_hit_s || detach_hit_s) begin
      intr_d = 1'b1;
    end else if (intr_clr_i) begin
      intr_d = 1'b0;
    end else begin
      intr_d = intr_q;
    end
  end

  // Output flops
  always_ff @(posedge usb_clk_i or posedge usb_rst_i) begin
    if (usb_rst_i) begin
      dev_attached_q <= 1'b0;
      dev_speed_q    <= 1'b0;
      attach_evt_q   <= 1'b0;
      detach_evt_q   <= 1'b0;
      intr_q         <= 1'b0;
    end else begin
      dev_attached_q <= dev_attached_d;
      dev_speed_q    <= dev_speed_d;
      attach_evt_q   <= attach_evt_d;
      detach_evt_q   <= detach_evt_d;
      intr_q         <= intr_d;
    end
  end

  assign dev_attached_o = dev_attached_q;
  assign dev_speed_o    = dev_speed_q;
  assign attach_evt_o   = attach_evt_q;
  assign detach_evt_o   = detach_evt_q;
  assign intr_o         = intr_q;

endmodule
